pattern_frame_generator: RTL and testbench
==========================================

Name: pattern_frame_generator

Overview:
- Synthesizable, parametrised successor to the file-driven image source.
- Produces frames of configurable size, channel count and channel width from built-in patterns: ramp, colour bars, checkerboard, constant.
- Honours FIFO back-pressure, marks start-of-frame and end-of-line, inserts optional inter-line gaps, and stops after N frames.
- Sits in front of the vip_core input FIFO. Usable both in simulation and on-board for bring-up.

Parameters:
- CH_BITS, 8, bits per colour channel.
- CHANNELS, 3, channels per pixel. Channel 0 occupies the MSBs. DWIDTH = CH_BITS*CHANNELS is derived, not overridable.
- DIM_BITS, 11, width of the width, height and x/y counters.
- FRAME_BITS, 11, width of the frame counters.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse. Latches cfg_* and begins generation; ignored while busy=1.
- abort  in  1  stops generation at the next edge.
- cfg_width  in  DIM_BITS  pixels per line.
- cfg_height  in  DIM_BITS  lines per frame.
- cfg_num_frame  in  FRAME_BITS  frames to emit; 0 = run until abort.
- cfg_mode  in  2  pattern select: 0 ramp, 1 colour bars, 2 checkerboard, 3 constant.
- cfg_const  in  DWIDTH  pixel value used in mode 3.
- cfg_gap  in  4  idle cycles inserted after every line.
- fifo_full  in  1  FIFO almost-full; must assert with at least 1 entry of margin.
- fifo_data  out  DWIDTH  pixel data.
- fifo_wrreq  out  1  write strobe.
- fifo_sof  out  1  qualifies the first pixel of a frame.
- fifo_eol  out  1  qualifies the last pixel of a line.
- busy  out  1  high from LOAD until return to IDLE.
- done  out  1  one-cycle pulse after the last pixel of the last frame.
- frame_count  out  FRAME_BITS  completed frames in the current run.

Behaviour:
- Reset values: all outputs 0; state IDLE; x, y, gap and bar counters 0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, GAP, DONE.
  - IDLE: on start -> LOAD, latching all cfg_* into shadow registers. cfg_* changes afterwards have no effect until the next start.
  - LOAD: clear x, y, frame_count and bar counters. If width==0 or height==0 -> DONE; else -> RUN.
  - RUN, each edge:
    - fifo_full=1: fifo_wrreq<=0 and counters hold.
    - fifo_full=0: fifo_wrreq<=1, fifo_data<=pixel(x,y,frame), fifo_sof<=(x==0&&y==0), fifo_eol<=(x==width-1), then x increments.
  - End of line (x==width-1 written): x<=0; y increments, or wraps to 0 with frame_count increment at y==height-1.
  - After a line: if cfg_gap!=0 -> GAP; else remain in RUN.
  - After a line that completes frame num_frame (num_frame!=0): -> DONE, and the GAP after that final line is skipped.
  - GAP: fifo_wrreq=0 for exactly cfg_gap cycles, then -> RUN.
  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
- Latency: start sampled at edge N; first fifo_wrreq visible after edge N+2 when fifo_full=0.
- fifo_sof and fifo_eol are 0 whenever fifo_wrreq=0.
- Patterns (f = frame_count, c = channel index):
  - Ramp: channel c = (x + y + f + c) mod 2^CH_BITS.
  - Colour bars:
    - Bar width bw = max(1, width>>3). A bar counter advances the bar index b every bw pixels, saturating at 7, and resets at each line start.
    - Pixel = BAR_RGB[b] with BAR_RGB = {7,6,3,2,5,4,1,0}. Order: white, yellow, cyan, green, magenta, red, blue, black.
    - Channel c is all-ones if bit (2 - c mod 3) of BAR_RGB[b] is set, else 0.
  - Checkerboard: all channels all-ones if x[3]^y[3]^f[0], else 0.
  - Constant: cfg_const.
- abort: from any non-IDLE state -> IDLE on the next edge. fifo_wrreq<=0, busy<=0, no done pulse; frame_count holds.
- abort and start in the same cycle: abort wins.
- Async reset mid-frame: immediate return to reset values; no partial-frame completion.
- num_frame=0: frames wrap frame_count modulo 2^FRAME_BITS indefinitely.
- width=1: every pixel has eol=1. width=1 and height=1: every pixel has sof=1 and eol=1.

Decomposition:
- Package vip_pattern_pkg holds:
  - mode constants MODE_RAMP, MODE_BARS, MODE_CHECK, MODE_CONST;
  - state encodings;
  - the BAR_RGB lookup.
- One sub-module, pattern_pixel_gen, is combinational. Inputs: x, y, frame, bar index, mode, const. Output: DWIDTH pixel.
- The FSM, counters and handshake stay in pattern_frame_generator.

Test Plan:
- Ramp, width 4, height 2, num_frame 1, gap 0, fifo_full=0 -> 8 consecutive writes, ch0 = 0,1,2,3,1,2,3,4; sof on write 1; eol on writes 4 and 8; done pulses once; frame_count=1.
- Bars, width 16, height 1 -> pixel pairs 0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000.
- Constant 0x123456, width 3, height 3, fifo_full toggling every other cycle -> exactly 9 writes, none while full was sampled high, order and markers intact.
- gap 3, width 2, height 2, num_frame 2 -> 3 idle cycles after lines 1-3, none after the final line; done after 8 writes.
- num_frame 0, width 2, height 2, abort after 10 writes -> wrreq low the next cycle, busy=0, no done, frame_count=2.
- Width 0 -> LOAD to DONE with zero writes; async reset asserted mid-line -> all outputs 0 immediately, and the next start restarts with sof on the first pixel.

Source files
------------

// File: rtl/vip_pattern_pkg.sv
// rtl/vip_pattern_pkg.sv - shared constants for the pattern frame generator
package vip_pattern_pkg;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // RGB on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'd7, 3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd0};

endpackage

// File: rtl/pattern_pixel_gen.sv
// rtl/pattern_pixel_gen.sv - combinational pixel value for the selected pattern
module pattern_pixel_gen
  import vip_pattern_pkg::*;
#(
  parameter int CH_BITS    = 8,
  parameter int CHANNELS   = 3,
  parameter int DIM_BITS   = 11,
  parameter int FRAME_BITS = 11,
  localparam int DWIDTH    = CH_BITS * CHANNELS
) (
  input  logic [DIM_BITS-1:0]   x,
  input  logic [DIM_BITS-1:0]   y,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [2:0]            bar,
  input  logic [1:0]            mode,
  input  logic [DWIDTH-1:0]     const_value,
  output logic [DWIDTH-1:0]     pixel
);

  logic [2:0] rgb;
  logic       check;

  always_comb begin
    pixel = '0;
    rgb   = BAR_RGB[bar];
    check = x[3] ^ y[3] ^ frame[0];
    if (mode == MODE_CONST) begin
      pixel = const_value;
    end else begin
      // channel 0 sits in the MSBs
      for (int c = 0; c < CHANNELS; c++) begin
        if (mode == MODE_RAMP)
          pixel[(CHANNELS-1-c)*CH_BITS +: CH_BITS] =
            CH_BITS'(x) + CH_BITS'(y) + CH_BITS'(frame) + CH_BITS'(c);
        else if (mode == MODE_BARS)
          pixel[(CHANNELS-1-c)*CH_BITS +: CH_BITS] = {CH_BITS{rgb[2 - (c % 3)]}};
        else
          pixel[(CHANNELS-1-c)*CH_BITS +: CH_BITS] = {CH_BITS{check}};
      end
    end
  end

endmodule

// File: rtl/pattern_frame_generator.sv
// rtl/pattern_frame_generator.sv - built-in pattern frame source for the vip_core input FIFO
module pattern_frame_generator
  import vip_pattern_pkg::*;
#(
  parameter int CH_BITS    = 8,
  parameter int CHANNELS   = 3,
  parameter int DIM_BITS   = 11,
  parameter int FRAME_BITS = 11,
  localparam int DWIDTH    = CH_BITS * CHANNELS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_BITS-1:0]   cfg_width,
  input  logic [DIM_BITS-1:0]   cfg_height,
  input  logic [FRAME_BITS-1:0] cfg_num_frame,
  input  logic [1:0]            cfg_mode,
  input  logic [DWIDTH-1:0]     cfg_const,
  input  logic [3:0]            cfg_gap,
  input  logic                  fifo_full,
  output logic [DWIDTH-1:0]     fifo_data,
  output logic                  fifo_wrreq,
  output logic                  fifo_sof,
  output logic                  fifo_eol,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] frame_count
);

  state_t state, state_next;

  logic [DIM_BITS-1:0]   width_q, height_q;
  logic [FRAME_BITS-1:0] num_frame_q;
  logic [1:0]            mode_q;
  logic [DWIDTH-1:0]     const_q;
  logic [3:0]            gap_q;

  logic [DIM_BITS-1:0]   x, y, bar_cnt, bar_w;
  logic [2:0]            bar_idx;
  logic [3:0]            gap_cnt;
  logic                  last_x, last_y, last_frame, write, line_end, gap_end;
  logic [DWIDTH-1:0]     pixel;
  logic                  wr_d, sof_d, eol_d, done_d, busy_d;

  assign bar_w      = ((width_q >> 3) == '0) ? DIM_BITS'(1) : (width_q >> 3);
  assign last_x     = (x == width_q - DIM_BITS'(1));
  assign last_y     = (y == height_q - DIM_BITS'(1));
  assign last_frame = (num_frame_q != '0) && ((frame_count + FRAME_BITS'(1)) == num_frame_q);
  assign write      = (state == ST_RUN) && !fifo_full && !abort;
  assign line_end   = write && last_x;
  assign gap_end    = (gap_cnt == gap_q - 4'd1);

  pattern_pixel_gen #(
    .CH_BITS    (CH_BITS),
    .CHANNELS   (CHANNELS),
    .DIM_BITS   (DIM_BITS),
    .FRAME_BITS (FRAME_BITS)
  ) u_pixel (
    .x           (x),
    .y           (y),
    .frame       (frame_count),
    .bar         (bar_idx),
    .mode        (mode_q),
    .const_value (const_q),
    .pixel       (pixel)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = (width_q == '0 || height_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        // the gap after the final line is skipped
        if (line_end) begin
          if (last_y && last_frame) state_next = ST_DONE;
          else if (gap_q != 4'd0)   state_next = ST_GAP;
        end
      end
      ST_GAP:  if (gap_end) state_next = ST_RUN;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    wr_d   = write;
    sof_d  = write && (x == '0) && (y == '0);
    eol_d  = line_end;
    done_d = (state == ST_DONE) && !abort;
    busy_d = (state_next != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_data  <= '0;
      fifo_wrreq <= 1'b0;
      fifo_sof   <= 1'b0;
      fifo_eol   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fifo_wrreq <= wr_d;
      fifo_sof   <= sof_d;
      fifo_eol   <= eol_d;
      busy       <= busy_d;
      done       <= done_d;
      if (write) fifo_data <= pixel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width_q     <= '0;
      height_q    <= '0;
      num_frame_q <= '0;
      mode_q      <= '0;
      const_q     <= '0;
      gap_q       <= '0;
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      gap_cnt     <= '0;
    end else begin
      if (state == ST_IDLE && start && !abort) begin
        width_q     <= cfg_width;
        height_q    <= cfg_height;
        num_frame_q <= cfg_num_frame;
        mode_q      <= cfg_mode;
        const_q     <= cfg_const;
        gap_q       <= cfg_gap;
      end
      if (state == ST_LOAD) begin
        x           <= '0;
        y           <= '0;
        frame_count <= '0;
        bar_cnt     <= '0;
        bar_idx     <= '0;
        gap_cnt     <= '0;
      end
      if (write) begin
        if (last_x) begin
          x       <= '0;
          bar_cnt <= '0;
          bar_idx <= '0;
          if (last_y) begin
            y           <= '0;
            frame_count <= frame_count + FRAME_BITS'(1);
          end else begin
            y <= y + DIM_BITS'(1);
          end
        end else begin
          x <= x + DIM_BITS'(1);
          if (bar_cnt == bar_w - DIM_BITS'(1)) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + DIM_BITS'(1);
          end
        end
      end
      if (state == ST_GAP) gap_cnt <= gap_end ? 4'd0 : gap_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_pattern_frame_generator.sv
// tb/tb_pattern_frame_generator.sv - scoreboard bench for pattern_frame_generator
module tb_pattern_frame_generator;

  logic        clock = 1'b0;
  logic        reset, start, abort, fifo_full;
  logic [10:0] cfg_width, cfg_height, cfg_num_frame;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_const;
  logic [3:0]  cfg_gap;
  logic [23:0] fifo_data;
  logic        fifo_wrreq, fifo_sof, fifo_eol, busy, done;
  logic [10:0] frame_count;

  pattern_frame_generator dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_num_frame(cfg_num_frame),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_gap(cfg_gap),
    .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
    .fifo_sof(fifo_sof), .fifo_eol(fifo_eol), .busy(busy), .done(done),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        exp_q[$];
  int          wr_cyc[$];
  int          total = 0, bad = 0;
  int          cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic        full_at_edge = 1'b0;
  exp_t        exp_e, act_e;

  always @(posedge clock) begin
    cyc++;
    full_at_edge <= fifo_full;
  end

  // monitor: every presented write is popped from the scoreboard and compared
  always @(negedge clock) begin
    if (fifo_wrreq === 1'b1) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      act_e = '{data: fifo_data, sof: fifo_sof, eol: fifo_eol};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_write actual=%h sof=%b eol=%b required=no write", fifo_data, fifo_sof, fifo_eol);
      end else begin
        exp_e = exp_q.pop_front();
        if (act_e !== exp_e) begin
          bad++;
          $display("FAIL pixel_write#%0d actual=%h/%b/%b required=%h/%b/%b", wr_cnt,
                   act_e.data, act_e.sof, act_e.eol, exp_e.data, exp_e.sof, exp_e.eol);
        end
      end
      total++;
      if (full_at_edge !== 1'b0) begin
        bad++;
        $display("FAIL write_while_full actual=%b required=0", full_at_edge);
      end
    end else if (fifo_sof === 1'b1 || fifo_eol === 1'b1) begin
      total++;
      bad++;
      $display("FAIL marker_without_write actual=%b%b required=00", fifo_sof, fifo_eol);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] model_pix(input int md, input int px, input int py, input int pf,
                                            input int w, input logic [23:0] cv);
    logic [23:0] p;
    logic [2:0]  rgb;
    logic [7:0]  ch;
    int          bw, b;
    logic        on;
    p  = '0;
    bw = (w / 8 > 1) ? w / 8 : 1;
    b  = px / bw;
    if (b > 7) b = 7;
    case (b)
      0: rgb = 3'b111; 1: rgb = 3'b110; 2: rgb = 3'b011; 3: rgb = 3'b010;
      4: rgb = 3'b101; 5: rgb = 3'b100; 6: rgb = 3'b001; default: rgb = 3'b000;
    endcase
    on = (((px / 8) % 2) ^ ((py / 8) % 2) ^ (pf % 2)) != 0;
    for (int c = 0; c < 3; c++) begin
      case (md)
        0:       ch = 8'((px + py + pf + c) % 256);
        1:       ch = rgb[2-c] ? 8'hFF : 8'h00;
        2:       ch = on ? 8'hFF : 8'h00;
        default: ch = cv[23-8*c -: 8];
      endcase
      p[23-8*c -: 8] = ch;
    end
    return p;
  endfunction

  // fp: 0 never full, 1 toggling, 2 random; ab/rs: abort or reset after that many writes
  task automatic run_cfg(input int w, input int h, input int nf, input int md, input logic [23:0] cv,
                         input int gp, input int fp, input int ab, input int rs);
    int  n_exp, start_cyc, mism, px, py, pf;
    bit  finished;
    exp_q.delete();
    wr_cyc.delete();
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = 0;
    n_exp = (w == 0 || h == 0) ? 0 : ((nf != 0) ? nf * w * h : ((ab != 0) ? ab : rs));
    for (int i = 0; i < n_exp; i++) begin
      px = i % w;
      py = (i / w) % h;
      pf = (i / (w * h)) % 2048;
      exp_q.push_back('{data: model_pix(md, px, py, pf, w, cv), sof: (px == 0 && py == 0), eol: (px == w - 1)});
    end
    @(negedge clock); #1;
    cfg_width = 11'(w); cfg_height = 11'(h); cfg_num_frame = 11'(nf);
    cfg_mode = 2'(md); cfg_const = cv; cfg_gap = 4'(gp);
    fifo_full = 1'b0; abort = 1'b0; start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cfg_width = 11'($urandom); cfg_height = 11'($urandom); cfg_num_frame = 11'($urandom);
    cfg_mode = 2'($urandom); cfg_const = 24'($urandom); cfg_gap = 4'($urandom);
    finished = 0;
    for (int t = 0; t < 5000 && !finished; t++) begin
      if (ab != 0 && wr_cnt == ab) begin
        abort = 1'b1;
        fifo_full = 1'b0;
        @(negedge clock); #1;
        abort = 1'b0;
        check("abort_wrreq", fifo_wrreq, 0);
        check("abort_busy", busy, 0);
        check("abort_frame_count", frame_count, ab / (w * h));
        finished = 1;
      end else if (rs != 0 && wr_cnt == rs) begin
        #2 reset = 1'b1;
        #1 check("async_reset_outputs",
                 {fifo_data, fifo_wrreq, fifo_sof, fifo_eol, busy, done, frame_count}, 0);
        reset = 1'b0;
        exp_q.delete();
        finished = 1;
      end else begin
        fifo_full = (fp == 1) ? (cyc % 2 == 1) : (fp == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(negedge clock); #1;
        if (done_cnt > 0) finished = 1;
      end
    end
    if (!finished) check("run_timeout", 0, 1);
    fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    if (ab == 0 && rs == 0) begin
      check("writes_left", exp_q.size(), 0);
      check("done_count", done_cnt, 1);
      check("final_frame_count", frame_count, (n_exp == 0) ? 0 : nf);
      check("busy_idle", busy, 0);
      if (fp == 0) begin
        if (n_exp == 0 || wr_cyc.size() == 0) begin
          check("done_latency", done_cyc, start_cyc + 2);
          check("write_count", wr_cyc.size(), n_exp);
        end else begin
          check("first_write_latency", wr_cyc[0], start_cyc + 2);
          mism = 0;
          for (int i = 1; i < wr_cyc.size(); i++)
            if (wr_cyc[i] - wr_cyc[i-1] != 1 + ((i % w == 0) ? gp : 0)) mism++;
          check("line_gap_timing", mism, 0);
          check("done_latency", done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        end
      end
    end else if (ab != 0) begin
      check("abort_no_done", done_cnt, 0);
      check("abort_no_extra_write", wr_cnt, ab);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_num_frame = '0;
    cfg_mode = '0; cfg_const = '0; cfg_gap = '0;
    #12;
    check("reset_state", {fifo_data, fifo_wrreq, fifo_sof, fifo_eol, busy, done, frame_count}, 0);
    @(negedge clock);
    reset = 1'b0;

    run_cfg(4, 2, 1, 0, 24'h0, 0, 0, 0, 0);          // ramp
    run_cfg(16, 1, 1, 1, 24'h0, 0, 0, 0, 0);         // colour bars
    run_cfg(3, 3, 1, 3, 24'h123456, 0, 1, 0, 0);     // constant, toggling back-pressure
    run_cfg(2, 2, 2, 0, 24'h0, 3, 0, 0, 0);          // inter-line gap
    run_cfg(2, 2, 0, 2, 24'h0, 0, 0, 10, 0);         // endless run stopped by abort
    run_cfg(0, 5, 1, 0, 24'h0, 0, 0, 0, 0);          // zero width
    run_cfg(8, 4, 1, 0, 24'h0, 0, 0, 0, 5);          // async reset mid-line
    run_cfg(5, 2, 1, 2, 24'h0, 0, 0, 0, 0);          // restart after reset
    run_cfg(1, 1, 2, 0, 24'h0, 2, 0, 0, 0);          // single-pixel frames

    // start and abort together while idle: abort wins
    @(negedge clock); #1;
    cfg_width = 11'd4; cfg_height = 11'd1; cfg_num_frame = 11'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clock); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    @(negedge clock); #1;
    check("start_abort_wrreq", fifo_wrreq, 0);

    for (int k = 0; k < 8; k++)
      run_cfg($urandom_range(1, 20), $urandom_range(1, 6), $urandom_range(1, 3),
              $urandom_range(0, 3), 24'($urandom), $urandom_range(0, 3),
              (k % 2 == 0) ? 2 : 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
